mem_access_stage: RTL

- EX/MEM boundary stage directly downstream of the ALU.
- Registers `ALUResult` together with the control bits that travel with it.
- Runs a request/acknowledge FSM to a byte-wide data memory for LBU/SB, using `ALUResult` as the byte address.
- Delivers a muxed writeback result (ALU, zero-extended load byte, or PC+4) to the writeback stage.
- Stalls the upstream pipeline while a memory access is outstanding.

---
 rtl/mem_stage_pkg.sv | 17 +
 rtl/mem_watchdog.sv | 37 +++
 rtl/mem_access_stage.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and constants for the EX/MEM access stage
package mem_stage_pkg;

   typedef enum logic {
      IDLE,
      ACCESS
   } state_t;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10
   } result_src_t;

   localparam int BYTE_W = 8;

endpackage

// File: rtl/mem_watchdog.sv
// rtl/mem_watchdog.sv - counts ACCESS cycles without ack and flags an abandoned access
module mem_watchdog
   import mem_stage_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic ack,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Counter sits at zero outside ACCESS, so it is already clear on entry.
   always_comb begin
      count_d = '0;
      if (active && !ack) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = active && !ack && (count_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - EX/MEM stage with byte load/store handshake
// Optional access timeout and fault pulse enabled by MEM_TIMEOUT_EN.
module mem_access_stage
   import mem_stage_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] ALUResult,
   input  logic [DATA_WIDTH-1:0] WriteData,
   input  logic [DATA_WIDTH-1:0] PCPlus4,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic                  RegWrite,
   input  logic [4:0]            Rd,
   input  logic [1:0]            ResultSrc,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [BYTE_W-1:0]     mem_wdata,
   input  logic [BYTE_W-1:0]     mem_rdata,
   input  logic                  mem_ack,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] ResultW,
   output logic [4:0]            RdW,
   output logic                  RegWriteW,
   output logic                  fault
);

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   addr_q, addr_d;
   logic [BYTE_W-1:0]       wdata_q, wdata_d;
   logic                    we_q, we_d;
   logic [4:0]              rd_q, rd_d;
   logic                    regwrite_q, regwrite_d;
   logic [1:0]              src_q, src_d;
   logic [DATA_WIDTH-1:0]   pc4_q, pc4_d;
   logic                    out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0]   result_q, result_d;
   logic [4:0]              rdw_q, rdw_d;
   logic                    regwritew_q, regwritew_d;
   logic                    fault_q, fault_d;
   logic                    accept;
   logic                    timeout_hit;
   logic                    unused_bits;

   function automatic logic [DATA_WIDTH-1:0] pick_result(
      input logic [1:0]            src,
      input logic [DATA_WIDTH-1:0] alu,
      input logic [DATA_WIDTH-1:0] pc4,
      input logic [BYTE_W-1:0]     load_byte
   );
      case (src)
         RES_MEM: return {{(DATA_WIDTH-BYTE_W){1'b0}}, load_byte};
         RES_PC4: return pc4;
         default: return alu;
      endcase
   endfunction

`ifdef MEM_TIMEOUT_EN
   mem_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .active (state_q == ACCESS),
      .ack    (mem_ack),
      .expired(timeout_hit)
   );
   assign unused_bits = ^WriteData[DATA_WIDTH-1:BYTE_W];
`else
   assign timeout_hit = 1'b0;
   assign unused_bits = ^{WriteData[DATA_WIDTH-1:BYTE_W], TIMEOUT_CYCLES[0]};
`endif

   assign accept = in_valid && (state_q == IDLE) && !flush;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      we_d        = we_q;
      rd_d        = rd_q;
      regwrite_d  = regwrite_q;
      src_d       = src_q;
      pc4_d       = pc4_q;
      out_valid_d = 1'b0;
      result_d    = result_q;
      rdw_d       = rdw_q;
      regwritew_d = regwritew_q;
      fault_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept && (MemRead || MemWrite)) begin
               state_d    = ACCESS;
               addr_d     = ALUResult;
               wdata_d    = WriteData[BYTE_W-1:0];
               we_d       = MemWrite;
               rd_d       = Rd;
               regwrite_d = RegWrite && !MemWrite && (Rd != 5'd0);
               src_d      = ResultSrc;
               pc4_d      = PCPlus4;
            end else if (accept) begin
               out_valid_d = 1'b1;
               result_d    = pick_result(ResultSrc, ALUResult, PCPlus4, '0);
               rdw_d       = Rd;
               regwritew_d = RegWrite && (Rd != 5'd0);
            end
         end
         ACCESS: begin
            // An ack coinciding with the timeout still completes the access.
            if (mem_ack) begin
               state_d     = IDLE;
               out_valid_d = 1'b1;
               result_d    = pick_result(src_q, addr_q, pc4_q, mem_rdata);
               rdw_d       = rd_q;
               regwritew_d = regwrite_q;
            end else if (timeout_hit) begin
               state_d     = IDLE;
               out_valid_d = 1'b1;
               fault_d     = 1'b1;
               rdw_d       = rd_q;
               regwritew_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         we_q        <= 1'b0;
         rd_q        <= '0;
         regwrite_q  <= 1'b0;
         src_q       <= '0;
         pc4_q       <= '0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         rdw_q       <= '0;
         regwritew_q <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         we_q        <= we_d;
         rd_q        <= rd_d;
         regwrite_q  <= regwrite_d;
         src_q       <= src_d;
         pc4_q       <= pc4_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         rdw_q       <= rdw_d;
         regwritew_q <= regwritew_d;
         fault_q     <= fault_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign mem_req   = (state_q == ACCESS);
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign out_valid = out_valid_q;
   assign ResultW   = result_q;
   assign RdW       = rdw_q;
   assign RegWriteW = regwritew_q;
   assign fault     = fault_q;

endmodule
